onehot_pair_accum: RTL and testbench



---
 rtl/onehot_pkg.sv | 48 ++++
 rtl/onehot_encoder.sv | 22 ++
 rtl/onehot_pair_accum.sv | 77 +++++++
 tb/tb_onehot_pair_accum.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_pkg.sv
// Shared types and helpers for the one-hot pair accumulator: the FSM state,
// a width-generic lowest-set-bit encoder and a saturating/wrapping adder.
package onehot_pkg;

    localparam int MAX_N  = 256;
    localparam int MAX_IW = 8;
    localparam int MAX_W  = 64;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    typedef struct packed {
        logic              err;
        logic [MAX_IW-1:0] idx;
    } idx_res_t;

    // Only the low n bits of v are looked at; callers zero-extend narrower operands.
    function automatic idx_res_t onehot_idx(input logic [MAX_N-1:0] v, input int n);
        idx_res_t r;
        int       ones;
        r    = '0;
        ones = 0;
        for (int i = MAX_N - 1; i >= 0; i--) begin
            if (i < n && v[i]) begin
                ones++;
                r.idx = MAX_IW'(i);
            end
        end
        r.err = (ones != 1);
        return r;
    endfunction

    // w-bit add that either clamps to 2^w-1 or wraps mod 2^w.
    function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b,
                                                 input int w, input logic sat);
        logic [MAX_W:0] s;
        logic [MAX_W:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = ((MAX_W+1)'(1) << w) - (MAX_W+1)'(1);
        if (s > lim && sat)
            return lim[MAX_W-1:0];
        return MAX_W'(s & lim);
    endfunction

endpackage

// File: rtl/onehot_encoder.sv
// Combinational N-bit one-hot to index encoder; flags zero or multi-hot input.
module onehot_encoder
    import onehot_pkg::*;
#(
    parameter int N = 16,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          err
);

    idx_res_t res;

    always_comb begin
        res = onehot_idx(MAX_N'(onehot), N);
    end

    assign idx = IW'(res.idx);
    assign err = res.err;

endmodule

// File: rtl/onehot_pair_accum.sv
// Streaming one-hot pair accumulator: sums idx(a)+idx(b) over a frame and
// presents total, beat count and error flag on a registered valid/ready output.
module onehot_pair_accum
    import onehot_pkg::*;
#(
    parameter int N     = 16,
    parameter int W     = 16,
    parameter int CNT_W = 8,
    parameter int SAT   = 0,
    localparam int IW   = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_err
);

    state_t           state;
    logic [W-1:0]     acc, acc_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             err, err_next;
    logic [IW-1:0]    idx_a, idx_b;
    logic             err_a, err_b;
    logic [IW:0]      pair_sum;
    logic             accept;

    onehot_encoder #(.N(N)) u_enc_a (.onehot(in_a), .idx(idx_a), .err(err_a));
    onehot_encoder #(.N(N)) u_enc_b (.onehot(in_b), .idx(idx_b), .err(err_b));

    // A held result only blocks input when downstream is not taking it this cycle.
    assign in_ready  = !rst && (state == ACCUM || out_ready);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;

    assign pair_sum = {1'b0, idx_a} + {1'b0, idx_b};
    assign acc_next = W'(sat_add(MAX_W'(acc), MAX_W'(pair_sum), W, SAT != 0));
    assign cnt_next = CNT_W'(sat_add(MAX_W'(cnt), MAX_W'(1), CNT_W, 1'b1));
    assign err_next = err | err_a | err_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_err   <= 1'b0;
        end else if (accept && in_last) begin
            // Covers simultaneous release and reload: the new frame replaces the old.
            out_sum   <= acc_next;
            out_count <= cnt_next;
            out_err   <= err_next;
            acc       <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            state     <= HOLD;
        end else begin
            if (accept) begin
                acc <= acc_next;
                cnt <= cnt_next;
                err <= err_next;
            end
            if (state == HOLD && out_ready)
                state <= ACCUM;
        end
    end

endmodule

// File: tb/tb_onehot_pair_accum.sv
// Scoreboard bench: three instances (16-bit wrap, 5-bit wrap, 5-bit saturate)
// share one input stream; a reference model predicts each frame result.
module tb_onehot_pair_accum;

    typedef struct {
        logic [15:0] s16;
        logic [4:0]  s5w;
        logic [4:0]  s5s;
        logic [7:0]  cnt;
        logic        err;
    } exp_t;

    logic        clk, rst;
    logic        in_valid, in_last, out_ready;
    logic [15:0] in_a, in_b;
    logic        in_ready, out_valid, out_err;
    logic [15:0] out_sum;
    logic [7:0]  out_count;
    logic        in_ready_w, out_valid_w, out_err_w;
    logic [4:0]  out_sum_w;
    logic [7:0]  out_count_w;
    logic        in_ready_s, out_valid_s, out_err_s;
    logic [4:0]  out_sum_s;
    logic [7:0]  out_count_s;

    int checks = 0;
    int errors = 0;

    exp_t q[$];
    int   m_acc16, m_acc5w, m_acc5s, m_cnt;
    logic m_err, m_hold;

    onehot_pair_accum #(.N(16), .W(16), .CNT_W(8), .SAT(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count), .out_err(out_err));

    onehot_pair_accum #(.N(16), .W(5), .CNT_W(8), .SAT(0)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid_w),
        .out_ready(out_ready), .out_sum(out_sum_w), .out_count(out_count_w), .out_err(out_err_w));

    onehot_pair_accum #(.N(16), .W(5), .CNT_W(8), .SAT(1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_sum(out_sum_s), .out_count(out_count_s), .out_err(out_err_s));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int low_idx(input logic [15:0] v);
        int r = 0;
        for (int i = 15; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    // Model steps at the negedge using the values that the next posedge will see.
    always @(negedge clk) begin
        logic exp_ready, consumed, accept;
        int   pair;
        exp_t e;
        exp_ready = !rst && (!m_hold || out_ready);
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        chk("in_ready_w5", 32'(in_ready_w), 32'(exp_ready));
        chk("in_ready_s5", 32'(in_ready_s), 32'(exp_ready));
        chk("out_valid", 32'(out_valid), 32'(m_hold));
        chk("out_valid_s5", 32'(out_valid_s), 32'(m_hold));
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("sb_underflow", 32'(out_valid), 32'd0);
            end else begin
                e = q[0];
                chk("out_sum", 32'(out_sum), 32'(e.s16));
                chk("out_sum_w5", 32'(out_sum_w), 32'(e.s5w));
                chk("out_sum_s5", 32'(out_sum_s), 32'(e.s5s));
                chk("out_count", 32'(out_count), 32'(e.cnt));
                chk("out_count_w5", 32'(out_count_w), 32'(e.cnt));
                chk("out_err", 32'(out_err), 32'(e.err));
                chk("out_err_s5", 32'(out_err_s), 32'(e.err));
            end
        end
        if (rst) begin
            m_acc16 = 0; m_acc5w = 0; m_acc5s = 0; m_cnt = 0; m_err = 0; m_hold = 0;
            q.delete();
        end else begin
            consumed = m_hold && out_ready;
            accept   = in_valid && (!m_hold || out_ready);
            if (consumed) begin
                if (q.size() > 0) void'(q.pop_front());
                m_hold = 0;
            end
            if (accept) begin
                pair    = low_idx(in_a) + low_idx(in_b);
                m_acc16 = (m_acc16 + pair) % 65536;
                m_acc5w = (m_acc5w + pair) % 32;
                m_acc5s = (m_acc5s + pair > 31) ? 31 : m_acc5s + pair;
                m_cnt   = (m_cnt == 255) ? 255 : m_cnt + 1;
                m_err   = m_err || ($countones(in_a) != 1) || ($countones(in_b) != 1);
                if (in_last) begin
                    e.s16 = 16'(m_acc16); e.s5w = 5'(m_acc5w); e.s5s = 5'(m_acc5s);
                    e.cnt = 8'(m_cnt); e.err = m_err;
                    q.push_back(e);
                    m_acc16 = 0; m_acc5w = 0; m_acc5s = 0; m_cnt = 0; m_err = 0;
                    m_hold = 1;
                end
            end
        end
    end

    task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic last);
        int   n;
        logic took;
        in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
        n = 0;
        do begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!took && n < 50);
        if (!took) chk("beat_timeout", 32'(took), 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        int n;
        m_acc16 = 0; m_acc5w = 0; m_acc5s = 0; m_cnt = 0; m_err = 0; m_hold = 0;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Three-beat frame: 2+4+15+0+1+1
        beat(16'h0004, 16'h0010, 1'b0);
        beat(16'h8000, 16'h0001, 1'b0);
        beat(16'h0002, 16'h0002, 1'b1);
        @(negedge clk);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_sum", 32'(out_sum), 32'd23);
        chk("t1_count", 32'(out_count), 32'd3);
        chk("t1_err", 32'(out_err), 32'd0);
        @(posedge clk); #1;

        // Single-beat frame held under backpressure with a beat waiting.
        out_ready = 1'b0;
        beat(16'h8000, 16'h8000, 1'b1);
        in_valid = 1'b1; in_a = 16'h0001; in_b = 16'h0001; in_last = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_sum", 32'(out_sum), 32'd30);
            chk("hold_count", 32'(out_count), 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("release_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // Error frame followed by a clean frame, back to back.
        beat(16'h0000, 16'h0003, 1'b1);
        @(negedge clk);
        chk("err_flag", 32'(out_err), 32'd1);
        chk("err_sum", 32'(out_sum), 32'd0);
        @(posedge clk); #1;
        beat(16'h0001, 16'h0001, 1'b1);
        @(negedge clk);
        chk("err_clear", 32'(out_err), 32'd0);
        @(posedge clk); #1;

        // Overflow: 3 x 30 = 90 -> 26 wrapped, 31 saturated in the 5-bit instances.
        beat(16'h8000, 16'h8000, 1'b0);
        beat(16'h8000, 16'h8000, 1'b0);
        beat(16'h8000, 16'h8000, 1'b1);
        @(negedge clk);
        chk("ovf_wrap", 32'(out_sum_w), 32'd26);
        chk("ovf_sat", 32'(out_sum_s), 32'd31);
        chk("ovf_wide", 32'(out_sum), 32'd90);
        @(posedge clk); #1;

        // Back-to-back single-beat frames at full rate.
        for (int i = 0; i < 8; i++)
            beat(16'(1) << $urandom_range(15), 16'(1) << $urandom_range(15), 1'b1);
        @(posedge clk); #1;

        // Reset during beat 2 of a 4-beat frame, then a fresh frame.
        beat(16'h0100, 16'h0200, 1'b0);
        in_valid = 1'b1; in_a = 16'h0400; in_b = 16'h0400; in_last = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        beat(16'h0008, 16'h0008, 1'b1);
        @(negedge clk);
        chk("post_rst_sum", 32'(out_sum), 32'd6);
        chk("post_rst_count", 32'(out_count), 32'd1);
        @(posedge clk); #1;

        // Random traffic with backpressure, bad operands and a rare reset.
        for (int i = 0; i < 300; i++) begin
            out_ready = ($urandom_range(3) != 0);
            in_valid  = ($urandom_range(4) != 0);
            in_a      = ($urandom_range(7) == 0) ? 16'($urandom) : 16'(1) << $urandom_range(15);
            in_b      = ($urandom_range(7) == 0) ? 16'($urandom) : 16'(1) << $urandom_range(15);
            in_last   = ($urandom_range(3) == 0);
            rst       = ($urandom_range(99) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
